mix_columns_iter: RTL

//  Iterative, parametrised AES diffusion stage: MixColumns (forward) or InvMixColumns (inverse) on a 4x4 byte state.

---
 rtl/mix_columns_iter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns over a 4x4 byte state, COLS_PER_CYCLE columns per clock.
// A per-block bypass hands the accepted state straight to the output for the final round.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int ENABLE_INV     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inverse,
  input  logic         in_bypass,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int NGRP = 4 / COLS_PER_CYCLE;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  // Handshakes: a transfer happens on the rising edge where valid & ready are both high;
  // valid is never withdrawn and its payload never changes until that transfer.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   work_q, work_d;
  logic           inv_q, inv_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    col_v;
  logic           use_inv;

  assign use_inv = (ENABLE_INV != 0) ? inv_q : 1'b0;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // col[8r+:8] holds row r; multiples of 9/B/D/E are built from the x2/x4/x8 chain.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2[r] = xt(a[r]);
      x4[r] = xt(x2[r]);
      x8[r] = xt(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      if (inv)
        o[8*r +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                    ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                    ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                    ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      else
        o[8*r +: 8] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    inv_d    = inv_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    col_v    = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          inv_d   = in_inverse;
          cnt_d   = '0;
          state_d = in_bypass ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        // Columns of group cnt_q are rewritten in place; the rest pass through.
        for (int c = 0; c < 4; c++) begin
          if (CW'(c / COLS_PER_CYCLE) == cnt_q) begin
            for (int r = 0; r < 4; r++) col_v[8*r +: 8] = work_q[8*(4*r+c) +: 8];
            col_v = mix_col(col_v, use_inv);
            for (int r = 0; r < 4; r++) work_d[8*(4*r+c) +: 8] = col_v[8*r +: 8];
          end
        end
        if (cnt_q == CW'(NGRP - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_state = work_q;
  assign dbg_state = state_q;

endmodule
